d16_uart: RTL and testbench



---
 rtl/d16_uart_pkg.sv | 58 +++++
 rtl/d16_uart_if.sv | 23 ++
 rtl/d16_fifo.sv | 56 +++++
 rtl/d16_uart.sv | 287 ++++++++++++++++++++++++++++
 tb/tb_d16_uart.sv | 282 ++++++++++++++++++++++++++++
 5 files changed

// File: rtl/d16_uart_pkg.sv
// d16_uart_pkg: shared constants and types for the d16 UART.
// Holds the register offsets, the STATUS/CTRL bit positions, the TX/RX state
// encodings, the sticky-flag payload and the baud clamp helper.
package d16_uart_pkg;

   localparam int unsigned DATA_W = 16;
   localparam int unsigned BYTE_W = 8;
   localparam int unsigned ADDR_W = 2;
   localparam int unsigned BAUD_W = 16;

   // Register offsets
   localparam logic [ADDR_W-1:0] REG_DATA   = 2'd0;
   localparam logic [ADDR_W-1:0] REG_STATUS = 2'd1;
   localparam logic [ADDR_W-1:0] REG_CTRL   = 2'd2;
   localparam logic [ADDR_W-1:0] REG_BAUD   = 2'd3;

   // STATUS bit positions
   localparam int unsigned ST_RX_AVAIL = 0;
   localparam int unsigned ST_RX_FULL  = 1;
   localparam int unsigned ST_TX_BUSY  = 2;
   localparam int unsigned ST_TX_FULL  = 3;
   localparam int unsigned ST_RX_OVR   = 4;
   localparam int unsigned ST_FRM_ERR  = 5;
   localparam int unsigned ST_TX_OVR   = 6;

   // CTRL bit positions
   localparam int unsigned CTRL_RX_IE = 0;
   localparam int unsigned CTRL_TX_IE = 1;

   localparam logic [BAUD_W-1:0] BAUD_MIN = 16'd3;

   typedef enum logic [1:0] {
      TX_IDLE  = 2'd0,
      TX_START = 2'd1,
      TX_DATA  = 2'd2,
      TX_STOP  = 2'd3
   } tx_state_e;

   typedef enum logic [1:0] {
      RX_IDLE  = 2'd0,
      RX_START = 2'd1,
      RX_DATA  = 2'd2,
      RX_STOP  = 2'd3
   } rx_state_e;

   // Sticky error flags, ordered to match STATUS[6:4]
   typedef struct packed {
      logic tx_ovr;
      logic frm_err;
      logic rx_ovr;
   } sticky_t;

   // Divider values below the minimum are stored as the minimum
   function automatic logic [BAUD_W-1:0] clamp_baud(input logic [BAUD_W-1:0] v);
      return (v < BAUD_MIN) ? BAUD_MIN : v;
   endfunction

endpackage

// File: rtl/d16_uart_if.sv
// d16_uart_if: single-cycle d16 bus slave port (no ack).
// Ports: i_sel (chip select), i_wb_cyc, i_wb_we, i_wb_addr[1:0], i_wb_dat[15:0]
// driven by the master; o_wb_dat[15:0] returned combinationally by the slave.
interface d16_uart_if;
   import d16_uart_pkg::*;

   logic              i_sel;
   logic              i_wb_cyc;
   logic              i_wb_we;
   logic [ADDR_W-1:0] i_wb_addr;
   logic [DATA_W-1:0] i_wb_dat;
   logic [DATA_W-1:0] o_wb_dat;

   modport master (
      output i_sel, i_wb_cyc, i_wb_we, i_wb_addr, i_wb_dat,
      input  o_wb_dat
   );

   modport slave (
      input  i_sel, i_wb_cyc, i_wb_we, i_wb_addr, i_wb_dat,
      output o_wb_dat
   );
endinterface

// File: rtl/d16_fifo.sv
// d16_fifo: synchronous FIFO with simultaneous push/pop and show-ahead head.
// Ports: clk, rst_n (async active-low), push/din, pop, dout (current head),
// full, empty. DEPTH must be a power of two >= 2.
module d16_fifo #(
   parameter int unsigned WIDTH = 8,
   parameter int unsigned DEPTH = 4
) (
   input  logic             clk,
   input  logic             rst_n,
   input  logic             push,
   input  logic [WIDTH-1:0] din,
   input  logic             pop,
   output logic [WIDTH-1:0] dout,
   output logic             full,
   output logic             empty
);
   localparam int unsigned AW = $clog2(DEPTH);
   localparam logic [AW:0] DEPTH_C = (AW+1)'(DEPTH);

   logic [WIDTH-1:0] mem_q [DEPTH];
   logic [AW-1:0]    wr_ptr_q, wr_ptr_d;
   logic [AW-1:0]    rd_ptr_q, rd_ptr_d;
   logic [AW:0]      cnt_q, cnt_d;
   logic             push_ok, pop_ok;

   assign full    = (cnt_q == DEPTH_C);
   assign empty   = (cnt_q == '0);
   assign dout    = mem_q[rd_ptr_q];
   // A pop frees the slot that a same-cycle push into a full FIFO needs
   assign pop_ok  = pop && !empty;
   assign push_ok = push && (!full || pop_ok);

   // Pointer and occupancy update
   always_comb begin
      wr_ptr_d = wr_ptr_q + AW'(push_ok);
      rd_ptr_d = rd_ptr_q + AW'(pop_ok);
      cnt_d    = cnt_q + (AW+1)'(push_ok) - (AW+1)'(pop_ok);
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         wr_ptr_q <= '0;
         rd_ptr_q <= '0;
         cnt_q    <= '0;
      end else begin
         wr_ptr_q <= wr_ptr_d;
         rd_ptr_q <= rd_ptr_d;
         cnt_q    <= cnt_d;
      end
   end

   // Storage needs no reset; occupancy gates every read
   always_ff @(posedge clk) begin
      if (push_ok) mem_q[wr_ptr_q] <= din;
   end
endmodule

// File: rtl/d16_uart.sv
// d16_uart: memory-mapped UART with RX/TX FIFOs, baud divider and level IRQ.
// Ports: i_clk, i_reset_n (async active-low), bus (d16_uart_if slave:
// DATA/STATUS/CTRL/BAUD registers, zero-latency reads), i_rx (async serial
// in), o_tx (serial out, idle high), o_int (registered level interrupt).
module d16_uart
   import d16_uart_pkg::*;
#(
   parameter int unsigned       RX_DEPTH   = 8,
   parameter int unsigned       TX_DEPTH   = 4,
   parameter logic [BAUD_W-1:0] BAUD_RESET = 16'd216
) (
   input  logic       i_clk,
   input  logic       i_reset_n,
   d16_uart_if.slave  bus,
   input  logic       i_rx,
   output logic       o_tx,
   output logic       o_int
);

   logic wr_c, rd_c, wr_data_c, wr_status_c, wr_ctrl_c, wr_baud_c, rd_data_c;

   assign wr_c        = bus.i_sel & bus.i_wb_cyc & bus.i_wb_we;
   assign rd_c        = bus.i_sel & bus.i_wb_cyc & ~bus.i_wb_we;
   assign wr_data_c   = wr_c && (bus.i_wb_addr == REG_DATA);
   assign wr_status_c = wr_c && (bus.i_wb_addr == REG_STATUS);
   assign wr_ctrl_c   = wr_c && (bus.i_wb_addr == REG_CTRL);
   assign wr_baud_c   = wr_c && (bus.i_wb_addr == REG_BAUD);
   assign rd_data_c   = rd_c && (bus.i_wb_addr == REG_DATA);

   // Control/status registers
   logic [BAUD_W-1:0] baud_q, baud_d;
   logic [1:0]        ctrl_q, ctrl_d;
   sticky_t           sticky_q, sticky_d;
   logic              int_q, int_d;
   logic              rx_meta_q, rx_meta_d, rx_sync_q, rx_sync_d, rx_prev_q, rx_prev_d;

   // FIFO handshakes
   logic              tx_push_c, tx_pop_c, tx_full, tx_empty, tx_ovr_set_c, tx_busy_c;
   logic [BYTE_W-1:0] tx_head;
   logic              rx_push_c, rx_pop_c, rx_full, rx_empty, rx_ovr_set_c;
   logic              rx_push_req_c, frm_set_c;
   logic [BYTE_W-1:0] rx_head;

   // TX shifter
   tx_state_e         tx_state_q, tx_state_d;
   logic [BAUD_W-1:0] tx_cnt_q, tx_cnt_d, tx_len_q, tx_len_d;
   logic [2:0]        tx_idx_q, tx_idx_d;
   logic [BYTE_W-1:0] tx_shift_q, tx_shift_d;
   logic              tx_q, tx_d, tx_end_c;

   // RX sampler
   rx_state_e         rx_state_q, rx_state_d;
   logic [BAUD_W-1:0] rx_cnt_q, rx_cnt_d, rx_len_q, rx_len_d;
   logic [2:0]        rx_idx_q, rx_idx_d;
   logic [BYTE_W-1:0] rx_shift_q, rx_shift_d;
   logic [BAUD_W:0]   rx_half_c;
   logic              rx_end_c, rx_half_end_c;

   d16_fifo #(.WIDTH(BYTE_W), .DEPTH(TX_DEPTH)) u_tx_fifo (
      .clk   (i_clk),
      .rst_n (i_reset_n),
      .push  (tx_push_c),
      .din   (bus.i_wb_dat[BYTE_W-1:0]),
      .pop   (tx_pop_c),
      .dout  (tx_head),
      .full  (tx_full),
      .empty (tx_empty)
   );

   d16_fifo #(.WIDTH(BYTE_W), .DEPTH(RX_DEPTH)) u_rx_fifo (
      .clk   (i_clk),
      .rst_n (i_reset_n),
      .push  (rx_push_c),
      .din   (rx_shift_q),
      .pop   (rx_pop_c),
      .dout  (rx_head),
      .full  (rx_full),
      .empty (rx_empty)
   );

   // A pop in the same cycle makes room, so a full FIFO only overflows without one
   assign tx_push_c    = wr_data_c && (!tx_full || tx_pop_c);
   assign tx_ovr_set_c = wr_data_c && tx_full && !tx_pop_c;
   assign tx_busy_c    = (tx_state_q != TX_IDLE) || !tx_empty;
   assign rx_pop_c     = rd_data_c && !rx_empty;
   assign rx_push_c    = rx_push_req_c && (!rx_full || rx_pop_c);
   assign rx_ovr_set_c = rx_push_req_c && rx_full && !rx_pop_c;

   assign tx_end_c      = (tx_cnt_q == tx_len_q);
   assign rx_end_c      = (rx_cnt_q == rx_len_q);
   assign rx_half_c     = (17'(rx_len_q) + 17'd1) >> 1;
   assign rx_half_end_c = (17'(rx_cnt_q) == (rx_half_c - 17'd1));

   // Register writes, sticky flags (set beats clear), interrupt, synchronizer
   always_comb begin
      baud_d   = baud_q;
      ctrl_d   = ctrl_q;
      sticky_d = sticky_q;
      if (wr_baud_c) baud_d = clamp_baud(bus.i_wb_dat);
      if (wr_ctrl_c) ctrl_d = bus.i_wb_dat[1:0];
      if (wr_status_c) begin
         if (bus.i_wb_dat[ST_RX_OVR])  sticky_d.rx_ovr  = 1'b0;
         if (bus.i_wb_dat[ST_FRM_ERR]) sticky_d.frm_err = 1'b0;
         if (bus.i_wb_dat[ST_TX_OVR])  sticky_d.tx_ovr  = 1'b0;
      end
      if (rx_ovr_set_c) sticky_d.rx_ovr  = 1'b1;
      if (frm_set_c)    sticky_d.frm_err = 1'b1;
      if (tx_ovr_set_c) sticky_d.tx_ovr  = 1'b1;
      int_d     = (ctrl_q[CTRL_RX_IE] & ~rx_empty) | (ctrl_q[CTRL_TX_IE] & ~tx_busy_c);
      rx_meta_d = i_rx;
      rx_sync_d = rx_meta_q;
      rx_prev_d = rx_sync_q;
   end

   // TX FSM: each state lasts len+1 clocks; len is latched per bit
   always_comb begin
      tx_state_d = tx_state_q;
      tx_cnt_d   = tx_cnt_q + 16'd1;
      tx_len_d   = tx_len_q;
      tx_idx_d   = tx_idx_q;
      tx_shift_d = tx_shift_q;
      tx_d       = tx_q;
      tx_pop_c   = 1'b0;
      case (tx_state_q)
         TX_IDLE: begin
            tx_cnt_d = '0;
            tx_d     = 1'b1;
            if (!tx_empty) begin
               tx_pop_c   = 1'b1;
               tx_shift_d = tx_head;
               tx_len_d   = baud_q;
               tx_state_d = TX_START;
               tx_d       = 1'b0;
            end
         end
         TX_START: begin
            if (tx_end_c) begin
               tx_cnt_d   = '0;
               tx_len_d   = baud_q;
               tx_idx_d   = '0;
               tx_d       = tx_shift_q[0];
               tx_state_d = TX_DATA;
            end
         end
         TX_DATA: begin
            if (tx_end_c) begin
               tx_cnt_d = '0;
               tx_len_d = baud_q;
               if (tx_idx_q == 3'd7) begin
                  tx_d       = 1'b1;
                  tx_state_d = TX_STOP;
               end else begin
                  tx_idx_d   = tx_idx_q + 3'd1;
                  tx_shift_d = {1'b0, tx_shift_q[BYTE_W-1:1]};
                  tx_d       = tx_shift_q[1];
               end
            end
         end
         TX_STOP: begin
            if (tx_end_c) begin
               tx_cnt_d = '0;
               tx_len_d = baud_q;
               // Chain straight into the next start bit to keep frames gap-free
               if (!tx_empty) begin
                  tx_pop_c   = 1'b1;
                  tx_shift_d = tx_head;
                  tx_d       = 1'b0;
                  tx_state_d = TX_START;
               end else begin
                  tx_d       = 1'b1;
                  tx_state_d = TX_IDLE;
               end
            end
         end
         default: begin
            tx_d       = 1'b1;
            tx_state_d = TX_IDLE;
         end
      endcase
   end

   // RX FSM: mid-bit sampling after a half-period start check
   always_comb begin
      rx_state_d    = rx_state_q;
      rx_cnt_d      = rx_cnt_q + 16'd1;
      rx_len_d      = rx_len_q;
      rx_idx_d      = rx_idx_q;
      rx_shift_d    = rx_shift_q;
      rx_push_req_c = 1'b0;
      frm_set_c     = 1'b0;
      case (rx_state_q)
         RX_IDLE: begin
            rx_cnt_d = '0;
            if (rx_prev_q && !rx_sync_q) begin
               rx_len_d   = baud_q;
               rx_state_d = RX_START;
            end
         end
         RX_START: begin
            if (rx_half_end_c) begin
               rx_cnt_d   = '0;
               rx_idx_d   = '0;
               rx_state_d = rx_sync_q ? RX_IDLE : RX_DATA;
            end
         end
         RX_DATA: begin
            if (rx_end_c) begin
               rx_cnt_d   = '0;
               rx_len_d   = baud_q;
               rx_shift_d = {rx_sync_q, rx_shift_q[BYTE_W-1:1]};
               if (rx_idx_q == 3'd7) rx_state_d = RX_STOP;
               else                  rx_idx_d   = rx_idx_q + 3'd1;
            end
         end
         RX_STOP: begin
            if (rx_end_c) begin
               rx_cnt_d      = '0;
               rx_state_d    = RX_IDLE;
               frm_set_c     = ~rx_sync_q;
               rx_push_req_c = rx_sync_q;
            end
         end
         default: rx_state_d = RX_IDLE;
      endcase
   end

   always_ff @(posedge i_clk or negedge i_reset_n) begin
      if (!i_reset_n) begin
         baud_q     <= BAUD_RESET;
         ctrl_q     <= '0;
         sticky_q   <= '0;
         int_q      <= 1'b0;
         rx_meta_q  <= 1'b1;
         rx_sync_q  <= 1'b1;
         rx_prev_q  <= 1'b1;
         tx_state_q <= TX_IDLE;
         tx_cnt_q   <= '0;
         tx_len_q   <= '0;
         tx_idx_q   <= '0;
         tx_shift_q <= '0;
         tx_q       <= 1'b1;
         rx_state_q <= RX_IDLE;
         rx_cnt_q   <= '0;
         rx_len_q   <= '0;
         rx_idx_q   <= '0;
         rx_shift_q <= '0;
      end else begin
         baud_q     <= baud_d;
         ctrl_q     <= ctrl_d;
         sticky_q   <= sticky_d;
         int_q      <= int_d;
         rx_meta_q  <= rx_meta_d;
         rx_sync_q  <= rx_sync_d;
         rx_prev_q  <= rx_prev_d;
         tx_state_q <= tx_state_d;
         tx_cnt_q   <= tx_cnt_d;
         tx_len_q   <= tx_len_d;
         tx_idx_q   <= tx_idx_d;
         tx_shift_q <= tx_shift_d;
         tx_q       <= tx_d;
         rx_state_q <= rx_state_d;
         rx_cnt_q   <= rx_cnt_d;
         rx_len_q   <= rx_len_d;
         rx_idx_q   <= rx_idx_d;
         rx_shift_q <= rx_shift_d;
      end
   end

   // Zero-latency read mux; idle bus reads as zero
   always_comb begin
      bus.o_wb_dat = '0;
      if (rd_c) begin
         case (bus.i_wb_addr)
            REG_DATA:   bus.o_wb_dat = rx_empty ? 16'h0000 : {8'h00, rx_head};
            REG_STATUS: bus.o_wb_dat = {9'd0, sticky_q.tx_ovr, sticky_q.frm_err,
                                        sticky_q.rx_ovr, tx_full, tx_busy_c,
                                        rx_full, ~rx_empty};
            REG_CTRL:   bus.o_wb_dat = {14'd0, ctrl_q};
            default:    bus.o_wb_dat = baud_q;
         endcase
      end
   end

   assign o_tx  = tx_q;
   assign o_int = int_q;

endmodule

// File: tb/tb_d16_uart.sv
// tb_d16_uart: self-checking bench for d16_uart with a byte/queue-level model.
module tb_d16_uart;
   import d16_uart_pkg::*;

   logic clk = 1'b0;
   logic rst_n = 1'b0;
   logic rx = 1'b1;
   logic tx, intr;
   int   n_cmp = 0;
   int   n_err = 0;

   d16_uart_if bus();

   d16_uart #(.RX_DEPTH(8), .TX_DEPTH(4), .BAUD_RESET(16'd216)) dut (
      .i_clk     (clk),
      .i_reset_n (rst_n),
      .bus       (bus.slave),
      .i_rx      (rx),
      .o_tx      (tx),
      .o_int     (intr)
   );

   always #5 clk = ~clk;

   task automatic bus_idle();
      bus.i_sel = 1'b0; bus.i_wb_cyc = 1'b0; bus.i_wb_we = 1'b0;
      bus.i_wb_addr = 2'd0; bus.i_wb_dat = 16'd0;
   endtask

   task automatic reg_write(input logic [1:0] a, input logic [15:0] d);
      @(negedge clk);
      bus.i_sel = 1'b1; bus.i_wb_cyc = 1'b1; bus.i_wb_we = 1'b1;
      bus.i_wb_addr = a; bus.i_wb_dat = d;
      @(negedge clk);
      bus_idle();
   endtask

   // Zero-time read of a non-popping register (no clock edge crossed)
   task automatic reg_peek(input logic [1:0] a, output logic [15:0] d);
      bus.i_sel = 1'b1; bus.i_wb_cyc = 1'b1; bus.i_wb_we = 1'b0; bus.i_wb_addr = a;
      #1 d = bus.o_wb_dat;
      bus_idle();
   endtask

   task automatic data_read(output logic [15:0] d);
      @(negedge clk);
      bus.i_sel = 1'b1; bus.i_wb_cyc = 1'b1; bus.i_wb_we = 1'b0; bus.i_wb_addr = REG_DATA;
      #1 d = bus.o_wb_dat;
      @(negedge clk);
      bus_idle();
   endtask

   // One serial frame at 8 clocks per bit, starting at the current negedge
   task automatic rx_frame(input logic [7:0] b, input logic stop);
      logic [9:0] bits;
      bits = {stop, b, 1'b0};
      for (int i = 0; i < 10; i++) begin
         rx = bits[i];
         repeat (8) @(negedge clk);
      end
      rx = 1'b1;
   endtask

   task automatic test_reset();
      logic [15:0] d;
      bus_idle();
      rst_n = 1'b0;
      repeat (3) @(negedge clk);
      n_cmp++; if (tx !== 1'b1) begin n_err++; $display("FAIL reset_tx: got %b want 1", tx); end
      n_cmp++; if (intr !== 1'b0) begin n_err++; $display("FAIL reset_int: got %b want 0", intr); end
      rst_n = 1'b1;
      @(negedge clk);
      reg_peek(REG_STATUS, d);
      n_cmp++; if (d !== 16'h0000) begin n_err++; $display("FAIL reset_status: got %h want 0000", d); end
      reg_peek(REG_BAUD, d);
      n_cmp++; if (d !== 16'd216) begin n_err++; $display("FAIL reset_baud: got %0d want 216", d); end
      reg_peek(REG_CTRL, d);
      n_cmp++; if (d !== 16'h0000) begin n_err++; $display("FAIL reset_ctrl: got %h want 0000", d); end
      // Reset in the middle of a start bit
      reg_write(REG_DATA, 16'h0055);
      repeat (20) @(negedge clk);
      n_cmp++; if (tx !== 1'b0) begin n_err++; $display("FAIL midframe_start: got %b want 0", tx); end
      rst_n = 1'b0;
      #1;
      n_cmp++; if (tx !== 1'b1) begin n_err++; $display("FAIL reset_async_tx: got %b want 1", tx); end
      @(negedge clk);
      rst_n = 1'b1;
      @(negedge clk);
      reg_peek(REG_STATUS, d);
      n_cmp++; if (d !== 16'h0000) begin n_err++; $display("FAIL reset_mid_status: got %h want 0000", d); end
   endtask

   task automatic test_tx_frame(input logic [7:0] b);
      logic [15:0] d;
      logic [9:0]  bits;
      reg_write(REG_BAUD, 16'($urandom_range(0, 2)));
      reg_peek(REG_BAUD, d);
      n_cmp++; if (d !== 16'd3) begin n_err++; $display("FAIL baud_clamp: got %0d want 3", d); end
      bits = {1'b1, b, 1'b0};
      reg_write(REG_DATA, {8'h00, b});
      n_cmp++; if (tx !== 1'b1) begin n_err++; $display("FAIL tx_pre_start: got %b want 1", tx); end
      for (int k = 0; k < 10; k++) begin
         for (int j = 0; j < 4; j++) begin
            @(negedge clk);
            n_cmp++;
            if (tx !== bits[k]) begin
               n_err++; $display("FAIL tx_bit byte=%h bit=%0d clk=%0d: got %b want %b", b, k, j, tx, bits[k]);
            end
            if (k == 4 && j == 0) begin
               reg_peek(REG_STATUS, d);
               n_cmp++; if (d[ST_TX_BUSY] !== 1'b1) begin n_err++; $display("FAIL tx_busy_mid: got %b want 1", d[ST_TX_BUSY]); end
            end
         end
      end
      @(negedge clk);
      reg_peek(REG_STATUS, d);
      n_cmp++; if (d !== 16'h0000) begin n_err++; $display("FAIL tx_done_status: got %h want 0000", d); end
      n_cmp++; if (tx !== 1'b1) begin n_err++; $display("FAIL tx_idle: got %b want 1", tx); end
   endtask

   task automatic test_tx_int();
      reg_write(REG_CTRL, 16'h0002);
      n_cmp++; if (intr !== 1'b0) begin n_err++; $display("FAIL tx_int_lag: got %b want 0", intr); end
      @(negedge clk);
      n_cmp++; if (intr !== 1'b1) begin n_err++; $display("FAIL tx_int_idle: got %b want 1", intr); end
      reg_write(REG_CTRL, 16'h0000);
      @(negedge clk);
      n_cmp++; if (intr !== 1'b0) begin n_err++; $display("FAIL tx_int_off: got %b want 0", intr); end
   endtask

   task automatic test_tx_overflow();
      logic [15:0] d;
      logic [7:0]  b [6];
      logic        wave [$];
      int          widx = 0;
      reg_write(REG_BAUD, 16'd3);
      for (int i = 0; i < 6; i++) b[i] = 8'($urandom);
      // One byte goes to the shifter, TX_DEPTH more fit, the last is dropped
      for (int i = 0; i < 5; i++) begin
         logic [9:0] bits;
         bits = {1'b1, b[i], 1'b0};
         for (int k = 0; k < 10; k++) repeat (4) wave.push_back(bits[k]);
      end
      @(negedge clk);
      bus.i_sel = 1'b1; bus.i_wb_cyc = 1'b1; bus.i_wb_we = 1'b1; bus.i_wb_addr = REG_DATA;
      for (int i = 0; i < 6; i++) begin
         bus.i_wb_dat = {8'h00, b[i]};
         @(negedge clk);
         if (i >= 1) begin
            n_cmp++;
            if (tx !== wave[widx]) begin n_err++; $display("FAIL ovf_wave idx=%0d: got %b want %b", widx, tx, wave[widx]); end
            widx++;
         end
      end
      bus_idle();
      while (widx < wave.size()) begin
         @(negedge clk);
         n_cmp++;
         if (tx !== wave[widx]) begin n_err++; $display("FAIL ovf_wave idx=%0d: got %b want %b", widx, tx, wave[widx]); end
         widx++;
      end
      @(negedge clk);
      reg_peek(REG_STATUS, d);
      n_cmp++; if (d !== 16'h0040) begin n_err++; $display("FAIL ovf_status: got %h want 0040", d); end
      reg_write(REG_STATUS, 16'h0040);
      reg_peek(REG_STATUS, d);
      n_cmp++; if (d !== 16'h0000) begin n_err++; $display("FAIL ovf_w1c: got %h want 0000", d); end
   endtask

   task automatic test_rx_frame(input logic [7:0] b);
      logic [15:0] d;
      int          waited = 0;
      reg_write(REG_BAUD, 16'd7);
      reg_write(REG_CTRL, 16'h0001);
      rx_frame(b, 1'b1);
      while (intr !== 1'b1 && waited < 8) begin
         @(negedge clk);
         waited++;
      end
      n_cmp++; if (intr !== 1'b1) begin n_err++; $display("FAIL rx_int_timeout: got %b want 1", intr); end
      reg_peek(REG_STATUS, d);
      n_cmp++; if (d !== 16'h0001) begin n_err++; $display("FAIL rx_status: got %h want 0001", d); end
      data_read(d);
      n_cmp++; if (d !== {8'h00, b}) begin n_err++; $display("FAIL rx_data: got %h want %h", d, {8'h00, b}); end
      n_cmp++; if (intr !== 1'b1) begin n_err++; $display("FAIL rx_int_lag: got %b want 1", intr); end
      @(negedge clk);
      n_cmp++; if (intr !== 1'b0) begin n_err++; $display("FAIL rx_int_clear: got %b want 0", intr); end
      data_read(d);
      n_cmp++; if (d !== 16'h0000) begin n_err++; $display("FAIL rx_empty_read: got %h want 0000", d); end
      reg_write(REG_CTRL, 16'h0000);
   endtask

   task automatic test_rx_errors();
      logic [15:0] d;
      logic [7:0]  q [$];
      logic [7:0]  b;
      reg_write(REG_BAUD, 16'd7);
      for (int i = 0; i < 9; i++) begin
         b = 8'($urandom);
         rx_frame(b, 1'b1);
         if (q.size() < 8) q.push_back(b);
      end
      repeat (4) @(negedge clk);
      reg_peek(REG_STATUS, d);
      n_cmp++; if (d !== 16'h0013) begin n_err++; $display("FAIL rxovr_status: got %h want 0013", d); end
      for (int i = 0; i < 8; i++) begin
         data_read(d);
         n_cmp++; if (d !== {8'h00, q[i]}) begin n_err++; $display("FAIL rxovr_data %0d: got %h want %h", i, d, {8'h00, q[i]}); end
      end
      data_read(d);
      n_cmp++; if (d !== 16'h0000) begin n_err++; $display("FAIL rxovr_drained: got %h want 0000", d); end
      reg_write(REG_STATUS, 16'h0010);
      reg_peek(REG_STATUS, d);
      n_cmp++; if (d !== 16'h0000) begin n_err++; $display("FAIL rxovr_w1c: got %h want 0000", d); end
      // Stop bit held low
      rx_frame(8'($urandom), 1'b0);
      repeat (12) @(negedge clk);
      reg_peek(REG_STATUS, d);
      n_cmp++; if (d !== 16'h0020) begin n_err++; $display("FAIL frm_status: got %h want 0020", d); end
      reg_write(REG_STATUS, 16'h0020);
      reg_peek(REG_STATUS, d);
      n_cmp++; if (d !== 16'h0000) begin n_err++; $display("FAIL frm_w1c: got %h want 0000", d); end
      // Short low glitch is a false start
      rx = 1'b0;
      repeat (2) @(negedge clk);
      rx = 1'b1;
      repeat (100) @(negedge clk);
      reg_peek(REG_STATUS, d);
      n_cmp++; if (d !== 16'h0000) begin n_err++; $display("FAIL glitch_status: got %h want 0000", d); end
   endtask

   task automatic test_simul_pop_push();
      logic [15:0] d, rd;
      logic [7:0]  q [$];
      logic [7:0]  b;
      reg_write(REG_BAUD, 16'd7);
      for (int i = 0; i < 8; i++) begin
         b = 8'($urandom);
         rx_frame(b, 1'b1);
         q.push_back(b);
      end
      b = 8'($urandom);
      // CPU read lands on the clock edge of the stop-bit push
      fork
         rx_frame(b, 1'b1);
         begin
            repeat (78) @(negedge clk);
            bus.i_sel = 1'b1; bus.i_wb_cyc = 1'b1; bus.i_wb_we = 1'b0; bus.i_wb_addr = REG_DATA;
            #1 rd = bus.o_wb_dat;
            @(negedge clk);
            bus_idle();
         end
      join
      n_cmp++; if (rd !== {8'h00, q[0]}) begin n_err++; $display("FAIL simul_read: got %h want %h", rd, {8'h00, q[0]}); end
      void'(q.pop_front());
      q.push_back(b);
      repeat (4) @(negedge clk);
      reg_peek(REG_STATUS, d);
      n_cmp++; if (d !== 16'h0003) begin n_err++; $display("FAIL simul_status: got %h want 0003", d); end
      for (int i = 0; i < 8; i++) begin
         data_read(d);
         n_cmp++; if (d !== {8'h00, q[i]}) begin n_err++; $display("FAIL simul_data %0d: got %h want %h", i, d, {8'h00, q[i]}); end
      end
      data_read(d);
      n_cmp++; if (d !== 16'h0000) begin n_err++; $display("FAIL simul_drained: got %h want 0000", d); end
   endtask

   initial begin
      test_reset();
      test_tx_frame(8'hA5);
      test_tx_frame(8'($urandom));
      test_tx_frame(8'($urandom));
      test_tx_int();
      test_tx_overflow();
      test_rx_frame(8'h3C);
      test_rx_frame(8'($urandom));
      test_rx_errors();
      test_simul_pop_push();
      $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
      $finish;
   end
endmodule
